// File: rtl/gcd_operand_feeder.sv
// gcd_operand_feeder
//   Upstream sequencer for a subtractive GCD core. It accepts one operand
//   pair over a valid/ready handshake and drives the core's shared data_in
//   bus: A with start high for one cycle, then B. It then waits for the core's
//   done level, reports job_done, and holds core_rst for CLR_CYCLES cycles.
//   The core parks in its done state, so this reset returns it to idle.
//   A pair with a zero operand would never terminate. Such a pair is
//   accepted, reported on err_zero and dropped, and the core is not touched.
//
// Parameters
//   W          operand / data_in width
//   CLR_CYCLES cycles core_rst is held after each job (>= 1)
//   TIMEOUT    maximum WAIT cycles before abort (only with GCD_FEED_TIMEOUT_EN)
//
// Optional feature (macro GCD_FEED_TIMEOUT_EN)
//   Defined  : a WAIT-cycle counter aborts a hung job with err_timeout.
//   Undefined: WAIT holds until done or rst; err_timeout is tied low.
//
// Ports
//   clk, rst         clock (rising edge), synchronous active-high reset
//   in_valid/in_ready/in_a/in_b  operand pair handshake
//   data_in, start   to the core operand bus / start
//   done             from the core (level, high until core reset)
//   core_rst         reset to the core
//   busy             job in flight (LOAD_A, LOAD_B, WAIT)
//   job_done, err_zero, err_timeout  one-cycle registered pulses
//   dbg_state        current FSM state (feeder_state_t encoding)
//
// Handshake: a pair transfers on a rising edge where in_valid and in_ready
// are both high. in_ready is high only in IDLE and does not depend on
// in_valid. There is no buffering, so only one job is in flight at a time.

module gcd_operand_feeder #(
  parameter int W          = 16,
  parameter int CLR_CYCLES = 2
`ifdef GCD_FEED_TIMEOUT_EN
  , parameter int TIMEOUT  = 65600
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W-1:0] data_in,
  output logic         start,
  input  logic         done,
  output logic         core_rst,
  output logic         busy,
  output logic         job_done,
  output logic         err_zero,
  output logic         err_timeout,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_CLEAR  = 3'd0,
    S_IDLE   = 3'd1,
    S_LOAD_A = 3'd2,
    S_LOAD_B = 3'd3,
    S_WAIT   = 3'd4
  } feeder_state_t;

  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

  feeder_state_t r_state;
  feeder_state_t w_next;
  logic [CW-1:0] r_clr_cnt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_job_done;
  logic          r_err_zero;
  logic          r_err_timeout;

  logic w_accept;
  logic w_zero;
  logic w_clr_last;
  logic w_timeout;

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_zero     = (in_a == '0) || (in_b == '0);
  assign w_clr_last = (r_clr_cnt == CLR_LAST);

`ifdef GCD_FEED_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_wait_cnt;

  // Counts WAIT cycles. It rests at zero outside WAIT, so every entry to
  // WAIT starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // State register, clear counter, operand capture and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_CLEAR;
      r_clr_cnt     <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_job_done    <= 1'b0;
      r_err_zero    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state <= w_next;

      if (r_state == S_CLEAR && !w_clr_last) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end else begin
        r_clr_cnt <= '0;
      end

      if (w_accept) begin
        r_a <= in_a;
        r_b <= in_b;
      end

      r_job_done    <= (r_state == S_WAIT) && done;
      r_err_zero    <= w_accept && w_zero;
      // A done on the same edge as the timeout takes priority.
      r_err_timeout <= w_timeout && !done;
    end
  end

  // Next-state logic. A done level seen outside WAIT is stale and is ignored.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR:  if (w_clr_last) w_next = S_IDLE;
      S_IDLE:   if (w_accept && !w_zero) w_next = S_LOAD_A;
      S_LOAD_A: w_next = S_LOAD_B;
      S_LOAD_B: w_next = S_WAIT;
      S_WAIT:   if (done || w_timeout) w_next = S_CLEAR;
      default:  w_next = S_CLEAR;
    endcase
  end

  // Moore decodes of the state register.
  always_comb begin
    data_in  = '0;
    start    = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b0;
    core_rst = 1'b0;
    case (r_state)
      S_CLEAR:  core_rst = 1'b1;
      S_IDLE:   in_ready = 1'b1;
      S_LOAD_A: begin
        data_in = r_a;
        start   = 1'b1;
        busy    = 1'b1;
      end
      S_LOAD_B: begin
        data_in = r_b;
        busy    = 1'b1;
      end
      S_WAIT:   busy = 1'b1;
      default:  core_rst = 1'b1;
    endcase
  end

  assign job_done    = r_job_done;
  assign err_zero    = r_err_zero;
  assign err_timeout = r_err_timeout;
  assign dbg_state   = r_state;

endmodule
